// File: rtl/led_event_blinker.sv
// Turns single-cycle event pulses into LED blinks (ON_CYCLES high, OFF_CYCLES low).
// Events that arrive mid-blink are queued and replayed back-to-back.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no blink in progress, pending is always 0
// ON    | led high, counter times ON_CYCLES
// OFF   | led low, counter times OFF_CYCLES, then replay or go idle
module led_event_blinker #(
    parameter int ON_CYCLES  = 2048,
    parameter int OFF_CYCLES = 2048,
    parameter int PEND_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              event_pulse,
    input  logic              clear_overflow,
    output logic              led,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [PEND_W-1:0] pending_nxt;
    logic              led_nxt, busy_nxt, overflow_nxt;
    logic              tc;
    logic              restart;
    logic              drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            pending  <= '0;
            overflow <= 1'b0;
            led      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            pending  <= pending_nxt;
            overflow <= overflow_nxt;
            led      <= led_nxt;
            busy     <= busy_nxt;
        end
    end

    assign tc      = (cnt == '0);
    assign restart = (state == S_OFF) && tc && ((pending != '0) || event_pulse);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (event_pulse) begin
                    state_nxt = S_ON;
                    cnt_nxt   = ON_LOAD;
                end
            end
            S_ON: begin
                if (tc) begin
                    state_nxt = S_OFF;
                    cnt_nxt   = OFF_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_OFF: begin
                if (tc) begin
                    if (restart) begin
                        state_nxt = S_ON;
                        cnt_nxt   = ON_LOAD;
                    end else begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        led_nxt     = (state_nxt == S_ON);
        busy_nxt    = (state_nxt != S_IDLE);
        pending_nxt = pending;
        drop        = 1'b0;
        // On a replay, a same-cycle event takes the consumed slot, so pending is unchanged.
        if (restart) begin
            if ((pending != '0) && !event_pulse) begin
                pending_nxt = pending - PEND_W'(1);
            end
        end else if ((state != S_IDLE) && event_pulse) begin
            if (pending == PEND_MAX) begin
                drop = 1'b1;
            end else begin
                pending_nxt = pending + PEND_W'(1);
            end
        end
        overflow_nxt = drop | (overflow & ~clear_overflow);
    end

endmodule

// File: doc/led_event_blinker.md
# led_event_blinker

Converts single-cycle event pulses, such as the debounced pushbutton strobe, into human-visible LED blinks. Each accepted event produces exactly one blink: LED on for ON_CYCLES, then off for OFF_CYCLES. Events arriving while a blink is in progress are counted and replayed back-to-back, so no event is merged or lost unless the pending counter saturates. The block sits between event sources in the clock-generator test design and the board status LEDs.

## Interface
- ON_CYCLES, 2048, LED-high duration per blink in clk cycles; legal range >= 1
- OFF_CYCLES, 2048, LED-low gap after each blink in clk cycles; legal range >= 1
- PEND_W, 4, width of the pending-event counter; maximum queued events is 2^PEND_W-1
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- event  input  1  each cycle sampled high counts as one event
- clear_overflow  input  1  clears sticky overflow flag
- led  output  1  blink output, registered
- busy  output  1  high whenever state is not IDLE, registered
- pending  output  PEND_W  events queued behind the current blink, registered
- overflow  output  1  sticky flag; an event was dropped

## Operation
- States are IDLE, ON and OFF. A single down-counter of width $clog2(max(ON_CYCLES,OFF_CYCLES)+1) times both phases.
- Reset sets state=IDLE, led=0, busy=0, pending=0, overflow=0 and counter=0. Reset mid-blink drops led on the next edge and discards pending events.
- IDLE:
  - If event=1, go to ON, load the counter for ON_CYCLES and set led=1. This event is consumed directly and does not increment pending.
  - pending is always 0 in IDLE.
- ON:
  - led stays 1.
  - When the counter expires after exactly ON_CYCLES cycles in ON, go to OFF, load OFF_CYCLES and set led=0.
- OFF:
  - led stays 0.
  - On the last OFF cycle, if pending>0 or event=1, go directly to ON with no IDLE cycle. Otherwise go to IDLE.
  - On that transition, pending decrements by 1 if it was non-zero. The only exception is when event=1 arrives in the same cycle: pending is then unchanged net, because one event is consumed and one is queued.
  - If pending=0 and event=1 on the last OFF cycle, that event is consumed directly.
- Queueing: in ON and OFF, apart from the consume case above, event=1 increments pending.
  - pending saturates at 2^PEND_W-1.
  - An event arriving at saturation is dropped and sets overflow.
- overflow stays set until clear_overflow=1. If clear and a new drop happen in the same cycle, set wins.
- busy equals (state != IDLE) and is registered alongside state.

## Timing
- Event-to-LED latency: event sampled high at edge k in IDLE gives led=1 after edge k, one cycle of latency.
- led high pulse width is exactly ON_CYCLES cycles. The low gap between queued blinks is exactly OFF_CYCLES cycles.
- Blink period for back-to-back queued events is exactly ON_CYCLES+OFF_CYCLES.
- After the last blink, busy stays high through the full OFF phase. busy falls at the same edge the state enters IDLE.
- An event arriving on the first IDLE cycle after OFF starts a blink with one cycle of latency. No extra recovery time is inserted.
- pending, overflow and led all update on the same edge as the state transition that causes them.

## Test plan
All scenarios use ON_CYCLES=4, OFF_CYCLES=3 and PEND_W=2, giving a maximum pending of 3.

- Single pulse at cycle 10 -> led high cycles 11-14, low 15-17; busy high 11-17, low from 18; pending stays 0.
- Pulses at cycles 10 and 12 -> blinks with led high 11-14 and 18-21; pending=1 from 13 to 17, then 0; busy falls at 25.
- event held high for 6 cycles starting at 10 -> pending climbs to 3 and saturates; overflow=1 from cycle 15; exactly 4 blinks total with period 7; clear_overflow at 40 -> overflow=0 at 41.
- Event exactly on the last OFF cycle with pending=1 -> next blink starts with no gap; pending stays 1 and then drains with one further blink.
- Reset asserted at cycle 13, mid-ON, with pending=2 -> led, busy and pending are all 0 at 14; no further blinks occur without new events.
- clear_overflow and a saturating event in the same cycle -> overflow remains 1.
